// File: rtl/matmul_tile_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_tile_sequencer
//
// Sequences one tile multiply on the systolic array wrapper. A start command
// carries the inner dimension K and the A/B operand base addresses. The
// sequencer then:
//   1. streams K lockstep read beats from the A/B operand buffers,
//   2. drives the wrapper's en/last in step with the returned read data,
//   3. waits out the fill/drain latency, and
//   4. flags the SIZE result rows as they leave the drain array.
// It is the only master of the array's en/last.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   start_i      job request, sampled only while idle
//   k_len_i      number of K beats for the job (0 completes at once)
//   a_base_i     A buffer start address
//   b_base_i     B buffer start address
//   abort_i      synchronous cancel of the running job
//   rd_req_o     operand read request (A and B in lockstep)
//   rd_addr_a_o  A read address
//   rd_addr_b_o  B read address
//   rd_gnt_i     buffer accepts the read this cycle; data returns next cycle
//   sa_en_o      to wrapper en_i
//   sa_last_o    to wrapper last_i
//   res_valid_o  wrapper c output holds a valid result row this cycle
//   res_row_o    index of that row, 0..SIZE-1
//   busy_o       high whenever a job is in progress
//   done_o       one-cycle pulse at job completion
// -----------------------------------------------------------------------------
module matmul_tile_sequencer #(
  parameter int SIZE      = 4,
  parameter int K_W       = 16,
  parameter int ADDR_W    = 10,
  parameter int DRAIN_LAT = 2 * SIZE + 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [K_W-1:0]           k_len_i,
  input  logic [ADDR_W-1:0]        a_base_i,
  input  logic [ADDR_W-1:0]        b_base_i,
  input  logic                     abort_i,
  output logic                     rd_req_o,
  output logic [ADDR_W-1:0]        rd_addr_a_o,
  output logic [ADDR_W-1:0]        rd_addr_b_o,
  input  logic                     rd_gnt_i,
  output logic                     sa_en_o,
  output logic                     sa_last_o,
  output logic                     res_valid_o,
  output logic [$clog2(SIZE)-1:0]  res_row_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int ROW_W = $clog2(SIZE);
  localparam int CNT_W = $clog2(DRAIN_LAT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_FLUSH,
    ST_COLLECT,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_len_q;
  logic [ADDR_W-1:0]   a_base_q, b_base_q;
  logic [K_W-1:0]      beat_q;
  logic [CNT_W-1:0]    drain_q;
  logic [ROW_W-1:0]    row_q;
  logic                en_q, last_q;

  // A grant only counts while feeding and not being cancelled; abort wins
  // over a coincident grant so that beat's data never enters the array.
  logic grant_ok;
  logic final_beat;
  logic accept_job;

  assign grant_ok   = (state_q == ST_FEED) && rd_gnt_i && !abort_i;
  assign final_beat = grant_ok && (beat_q == k_len_q - K_W'(1));
  assign accept_job = (state_q == ST_IDLE) && start_i && (k_len_i != '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_d; otherwise a latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = (k_len_i != '0) ? ST_FEED : ST_DONE;
        end
      end
      ST_FEED: begin
        if (abort_i)         state_d = ST_IDLE;
        else if (final_beat) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (abort_i)              state_d = ST_IDLE;
        else if (drain_q == '0)   state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (abort_i)                          state_d = ST_IDLE;
        else if (row_q == ROW_W'(SIZE - 1))   state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, job registers and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      k_len_q  <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      beat_q   <= '0;
      drain_q  <= '0;
      row_q    <= '0;
      en_q     <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;

      if (accept_job) begin
        k_len_q  <= k_len_i;
        a_base_q <= a_base_i;
        b_base_q <= b_base_i;
        beat_q   <= '0;
      end else if (grant_ok) begin
        beat_q <= beat_q + K_W'(1);
      end

      // Read data returns one cycle after its grant, so en/last are the
      // grant (and final-grant) flags delayed by one register.
      en_q   <= grant_ok;
      last_q <= final_beat;

      // Drain countdown is armed on the same edge that raises sa_last_o, so
      // it reads DRAIN_LAT during the last cycle and reaches 0 DRAIN_LAT
      // cycles later; COLLECT then begins DRAIN_LAT+1 cycles after last.
      if (final_beat) begin
        drain_q <= CNT_W'(DRAIN_LAT);
      end else if (state_q == ST_FLUSH && drain_q != '0) begin
        drain_q <= drain_q - CNT_W'(1);
      end

      // Row index only advances while staying in COLLECT; any exit clears
      // it so the next job starts at row 0.
      if (state_q == ST_COLLECT && state_d == ST_COLLECT) begin
        row_q <= row_q + ROW_W'(1);
      end else begin
        row_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Addresses are forced to 0 outside FEED so the buffers see a quiet bus;
  // the sum wraps naturally modulo 2^ADDR_W.
  assign rd_req_o    = (state_q == ST_FEED);
  assign rd_addr_a_o = rd_req_o ? a_base_q + ADDR_W'(beat_q) : '0;
  assign rd_addr_b_o = rd_req_o ? b_base_q + ADDR_W'(beat_q) : '0;
  assign sa_en_o     = en_q;
  assign sa_last_o   = last_q;
  assign res_valid_o = (state_q == ST_COLLECT);
  assign res_row_o   = row_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);

endmodule
